timer_divider_multi: RTL and testbench

- Parametrised successor to the single fixed divider/timer in the clocks block.
- Contains one free-running DIV_W-bit system divider plus NCH independent programmable timer channels.
- Each channel has an 8-bit counter, a modulo reload register, a control register selecting one of four divider taps, and a one-cycle interrupt pulse.
- Sits beside the CPU register bus; the full divider is exported for APU frame-sequencer and serial consumers.

---
 rtl/timer_divider_multi.sv | 127 ++++++++++++
 tb/tb_timer_divider_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_divider_multi.sv
// Free-running system divider plus NCH programmable 8-bit timer channels.
// Each channel counts falling edges of a selected divider tap and raises a one-cycle irq on overflow.
module timer_divider_multi #(
    parameter int DIV_W = 16,
    parameter int NCH   = 2,
    parameter int TAP0  = 9,
    parameter int TAP1  = 3,
    parameter int TAP2  = 5,
    parameter int TAP3  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    input  logic [3:0]       addr,
    input  logic [7:0]       d_in,
    output logic [7:0]       d_out,
    output logic [DIV_W-1:0] div,
    output logic [NCH-1:0]   irq
);

    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     div_next;
    logic                 div_wr;
    logic [NCH-1:0][7:0]  cnt_q;
    logic [NCH-1:0][7:0]  mod_q;
    logic [NCH-1:0][7:0]  mod_next;
    logic [NCH-1:0]       en_q;
    logic [NCH-1:0]       en_next;
    logic [NCH-1:0][1:0]  sel_q;
    logic [NCH-1:0][1:0]  sel_next;
    logic [NCH-1:0]       cnt_wr;
    logic [NCH-1:0]       mod_wr;
    logic [NCH-1:0]       ctl_wr;
    logic [NCH-1:0]       lvl_p0;
    logic [NCH-1:0]       lvl_p1;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       pend_q;
    logic [NCH-1:0]       irq_q;
    logic [7:0]           rd_data;

    function automatic logic tap_bit(input logic [1:0] sel, input logic [DIV_W-1:0] d);
        case (sel)
            2'd0:    tap_bit = d[TAP0];
            2'd1:    tap_bit = d[TAP1];
            2'd2:    tap_bit = d[TAP2];
            default: tap_bit = d[TAP3];
        endcase
    endfunction

    function automatic logic [3:0] reg_addr(input int ch, input int off);
        reg_addr = 4'(1 + 3 * ch + off);
    endfunction

    // Stage p0: next-state view of divider and control, so a write-induced fall ticks immediately
    always_comb begin
        div_wr   = cpu_wr && (addr == 4'd0);
        div_next = div_wr ? '0 : div_q + DIV_W'(1);
        for (int n = 0; n < NCH; n++) begin
            cnt_wr[n]   = cpu_wr && (addr == reg_addr(n, 0));
            mod_wr[n]   = cpu_wr && (addr == reg_addr(n, 1));
            ctl_wr[n]   = cpu_wr && (addr == reg_addr(n, 2));
            mod_next[n] = mod_wr[n] ? d_in : mod_q[n];
            en_next[n]  = ctl_wr[n] ? d_in[2] : en_q[n];
            sel_next[n] = ctl_wr[n] ? d_in[1:0] : sel_q[n];
            lvl_p0[n]   = en_next[n] & tap_bit(sel_next[n], div_next);
            tick[n]     = lvl_p1[n] & ~lvl_p0[n];
        end
    end

    always_comb begin
        rd_data = 8'hFF;
        if (addr == 4'd0) begin
            rd_data = div_q[DIV_W-1 -: 8];
        end
        for (int n = 0; n < NCH; n++) begin
            if (addr == reg_addr(n, 0)) rd_data = cnt_q[n];
            if (addr == reg_addr(n, 1)) rd_data = mod_q[n];
            if (addr == reg_addr(n, 2)) rd_data = {5'b11111, en_q[n], sel_q[n]};
        end
    end

    // Stage p1: registered state; overflow splits into wrap (pend set) then reload with irq
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            d_out  <= 8'h00;
            cnt_q  <= '0;
            mod_q  <= '0;
            en_q   <= '0;
            sel_q  <= '0;
            lvl_p1 <= '0;
            pend_q <= '0;
            irq_q  <= '0;
        end else begin
            div_q <= div_next;
            if (cpu_rd) begin
                d_out <= rd_data;
            end
            for (int n = 0; n < NCH; n++) begin
                mod_q[n]  <= mod_next[n];
                en_q[n]   <= en_next[n];
                sel_q[n]  <= sel_next[n];
                lvl_p1[n] <= lvl_p0[n];
                pend_q[n] <= 1'b0;
                irq_q[n]  <= 1'b0;
                if (pend_q[n]) begin
                    cnt_q[n] <= cnt_wr[n] ? d_in : mod_next[n];
                    irq_q[n] <= ~cnt_wr[n];
                end else if (cnt_wr[n]) begin
                    cnt_q[n] <= d_in;
                end else if (tick[n]) begin
                    if (cnt_q[n] == 8'hFF) begin
                        cnt_q[n]  <= 8'h00;
                        pend_q[n] <= 1'b1;
                    end else begin
                        cnt_q[n] <= cnt_q[n] + 8'd1;
                    end
                end
            end
        end
    end

    assign div = div_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_timer_divider_multi.sv
// Scoreboard bench for timer_divider_multi: reads push expected data, the d_out monitor pops and compares.
module tb_timer_divider_multi;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_wr = 1'b0;
    logic          cpu_rd = 1'b0;
    logic [3:0]    addr = 4'd0;
    logic [7:0]    d_in = 8'd0;
    logic [7:0]    d_out;
    logic [DW-1:0] div;
    logic [1:0]    irq;

    int n_err = 0;
    int n_chk = 0;

    logic [DW-1:0] m_div = '0;
    logic          rd_q = 1'b0;
    string         tag_q[$];
    logic [7:0]    val_q[$];

    timer_divider_multi #(.DIV_W(DW), .NCH(2), .TAP0(9), .TAP1(3), .TAP2(5), .TAP3(7)) dut (
        .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .addr(addr),
        .d_in(d_in), .d_out(d_out), .div(div), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference divider: free-running, cleared by reset or a write to addr 0
    always @(posedge clk) begin
        if (reset || (cpu_wr && addr == 4'd0)) m_div <= '0;
        else m_div <= m_div + DW'(1);
        rd_q <= cpu_rd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        string      t;
        logic [7:0] v;
        if (rd_q) begin
            if (val_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                t = tag_q.pop_front();
                v = val_q.pop_front();
                chk(t, 32'(d_out), 32'(v));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cpu_wr = 1'b1;
        addr   = a;
        d_in   = d;
        step();
        cpu_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        tag_q.push_back(tag);
        val_q.push_back(exp);
        cpu_rd = 1'b1;
        addr   = a;
        step();
        cpu_rd = 1'b0;
    endtask

    task automatic wait_div(input logic [DW-1:0] mask, input logic [DW-1:0] val);
        for (int i = 0; i < 200 && ((m_div & mask) != val); i++) step();
        if ((m_div & mask) != val) chk("wait_div_timeout", 32'(m_div & mask), 32'(val));
    endtask

    // Both channels end up at FF just before a 64-cycle boundary, where bit3 and bit5 fall together
    task automatic align_both();
        wait_div(DW'(6'h3F), DW'(50));
        wr(4'd1, 8'hFF);
        wr(4'd4, 8'hFF);
        wait_div(DW'(6'h3F), DW'(63));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_div", 32'(div), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_dout", 32'(d_out), 32'd0);
        reset = 1'b0;

        // Divider free-run and clear
        repeat (300) step();
        chk("div_300", 32'(div), 32'd300);
        rd("div_rd_300", 4'd0, 8'h01);
        wr(4'd0, 8'hA5);
        chk("div_after_wr", 32'(div), 32'(m_div));
        rd("div_rd_clr", 4'd0, 8'h00);
        chk("irq_idle", 32'(irq), 32'd0);

        // Ch0 counting and two-phase overflow
        wr(4'd2, 8'hF0);
        wr(4'd1, 8'hFE);
        wr(4'd3, 8'h05);
        rd("ctl0_rd", 4'd3, 8'hFD);
        wait_div(DW'(4'hF), DW'(15));
        rd("cnt_fe", 4'd1, 8'hFE);
        chk("irq_pre", 32'(irq), 32'd0);
        wait_div(DW'(4'hF), DW'(15));
        rd("cnt_ff", 4'd1, 8'hFF);
        chk("irq_wrap", 32'(irq), 32'd0);
        rd("cnt_00", 4'd1, 8'h00);
        chk("irq_pulse", 32'(irq), 32'd1);
        rd("cnt_reload", 4'd1, 8'hF0);
        chk("irq_once", 32'(irq), 32'd0);

        // CNT write in reload cycle cancels reload and irq
        wr(4'd1, 8'hFF);
        wait_div(DW'(4'hF), DW'(15));
        step();
        wr(4'd1, 8'h55);
        chk("irq_cancel", 32'(irq), 32'd0);
        rd("cnt_kept", 4'd1, 8'h55);
        chk("irq_cancel2", 32'(irq), 32'd0);

        // Modulo write in reload cycle is loaded straight into the counter
        wr(4'd1, 8'hFF);
        wait_div(DW'(4'hF), DW'(15));
        step();
        wr(4'd2, 8'h33);
        chk("irq_modwt", 32'(irq), 32'd1);
        rd("cnt_modwt", 4'd1, 8'h33);
        chk("irq_modwt_end", 32'(irq), 32'd0);

        // DIV write glitch tick with tap high, none with tap low
        wait_div(DW'(4'hF), DW'(0));
        wr(4'd1, 8'h10);
        wait_div(DW'(8), DW'(8));
        wr(4'd0, 8'h00);
        rd("glitch_tick", 4'd1, 8'h11);
        wait_div(DW'(4'hF), DW'(0));
        wr(4'd1, 8'h20);
        wr(4'd0, 8'h00);
        rd("glitch_none", 4'd1, 8'h20);

        // Two channels overflowing on the same edge
        wr(4'd5, 8'h44);
        wr(4'd6, 8'h06);
        align_both();
        chk("dual_pend", 32'(irq), 32'd0);
        step();
        chk("dual_irq", 32'(irq), 32'd3);
        rd("dual_cnt0", 4'd1, 8'h33);
        chk("dual_irq_end", 32'(irq), 32'd0);
        rd("dual_cnt1", 4'd4, 8'h44);

        // Reset during pending reload
        align_both();
        chk("rp_pend", 32'(irq), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rp_irq", 32'(irq), 32'd0);
        chk("rp_dout", 32'(d_out), 32'd0);
        step();
        chk("rp_irq2", 32'(irq), 32'd0);
        chk("rp_div", 32'(div), 32'(m_div));
        rd("rp_cnt0", 4'd1, 8'h00);
        rd("rp_mod0", 4'd2, 8'h00);
        rd("rp_ctl0", 4'd3, 8'hF8);
        rd("rp_cnt1", 4'd4, 8'h00);
        rd("rp_mod1", 4'd5, 8'h00);
        rd("rp_ctl1", 4'd6, 8'hF8);
        rd("rp_div_rd", 4'd0, m_div[DW-1 -: 8]);

        // Unmapped addresses
        wr(4'd7, 8'h07);
        wr(4'hF, 8'h12);
        rd("unmap7", 4'd7, 8'hFF);
        rd("unmapF", 4'hF, 8'hFF);
        rd("unmap_nowr", 4'd3, 8'hF8);

        repeat (3) step();
        chk("sb_empty", 32'(val_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
